// File: rtl/vdf_sq_ctrl_if.sv
// Handshake bundle between the VDF squaring controller,
// its start/result client and the squaring datapath.
interface vdf_sq_ctrl_if #(
    parameter int T_LEN = 64,
    parameter int DAT_W = 1089
);
    logic             i_start;
    logic [T_LEN-1:0] i_t;
    logic [DAT_W-1:0] i_sq_in;
    logic             o_busy;
    logic             o_mul_val;
    logic [DAT_W-1:0] o_mul_dat;
    logic             i_mul_rdy;
    logic             i_mul_val;
    logic [DAT_W-1:0] i_mul_dat;
    logic             o_res_val;
    logic [DAT_W-1:0] o_res_dat;
    logic             i_res_rdy;
    logic [T_LEN-1:0] o_iter_cnt;
    logic             o_err;

    modport slave (
        input  i_start, i_t, i_sq_in,
        input  i_mul_rdy, i_mul_val, i_mul_dat,
        input  i_res_rdy,
        output o_busy, o_mul_val, o_mul_dat,
        output o_res_val, o_res_dat,
        output o_iter_cnt, o_err
    );

    modport master (
        output i_start, i_t, i_sq_in,
        output i_mul_rdy, i_mul_val, i_mul_dat,
        output i_res_rdy,
        input  o_busy, o_mul_val, o_mul_dat,
        input  o_res_val, o_res_dat,
        input  o_iter_cnt, o_err
    );
endinterface

// File: rtl/vdf_sq_ctrl.sv
// Sequencer for repeated VDF squaring: issues one operand at a time
// to the datapath, feeds each result back, and reports after T squarings.
module vdf_sq_ctrl #(
    parameter int T_LEN = 64,
    parameter int DAT_W = 1089
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    vdf_sq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [T_LEN-1:0] t_q, t_d;
    logic [T_LEN-1:0] cnt_q, cnt_d;
    logic [T_LEN-1:0] cnt_inc;
    logic [DAT_W-1:0] op_q, op_d;
    logic             err_q, err_d;
    logic             mul_val;
    logic             res_val;

    assign cnt_inc = cnt_q + T_LEN'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        mul_val = 1'b0;
        res_val = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    t_d     = bus.i_t;
                    op_d    = bus.i_sq_in;
                    cnt_d   = '0;
                    state_d = (bus.i_t != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                mul_val = 1'b1;
                if (bus.i_mul_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.i_mul_val) begin
                    op_d    = bus.i_mul_dat;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == t_q) ? DONE : ISSUE;
                end
            end
            DONE: begin
                res_val = 1'b1;
                if (bus.i_res_rdy) begin
                    state_d = IDLE;
                end
            end
        endcase
        // A result arriving when nothing is in flight is a protocol fault.
        if (bus.i_mul_val && (state_q != WAIT)) begin
            err_d = 1'b1;
        end
    end

    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_mul_val  = mul_val;
    assign bus.o_mul_dat  = op_q;
    assign bus.o_res_val  = res_val;
    assign bus.o_res_dat  = op_q;
    assign bus.o_iter_cnt = cnt_q;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_vdf_sq_ctrl.sv
// Directed bench for vdf_sq_ctrl with an increment-by-one,
// four-cycle-latency datapath model.
module tb_vdf_sq_ctrl;

    localparam int T_LEN = 64;
    localparam int DAT_W = 1089;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vdf_sq_ctrl_if #(.T_LEN(T_LEN), .DAT_W(DAT_W)) bus ();

    vdf_sq_ctrl #(.T_LEN(T_LEN), .DAT_W(DAT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail = 0;

    logic             m_val = 1'b0;
    logic [DAT_W-1:0] m_dat = '0;
    logic [DAT_W-1:0] m_hold = '0;
    logic             m_pend = 1'b0;
    logic [2:0]       m_dly = '0;
    int               xfers = 0;
    logic             inj_val = 1'b0;

    assign bus.i_mul_val = m_val | inj_val;
    assign bus.i_mul_dat = m_dat;

    // result = operand + 1, returned four clocks after the transfer
    always @(posedge clk) begin
        m_val <= 1'b0;
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_dly  <= '0;
        end else begin
            if (m_pend) begin
                if (m_dly == 3'd1) begin
                    m_val  <= 1'b1;
                    m_dat  <= m_hold + DAT_W'(1);
                    m_pend <= 1'b0;
                end else begin
                    m_dly <= m_dly - 3'd1;
                end
            end
            if (bus.o_mul_val && bus.i_mul_rdy) begin
                m_hold <= bus.o_mul_dat;
                m_dly  <= 3'd3;
                m_pend <= 1'b1;
                xfers  <= xfers + 1;
            end
        end
    end

    task automatic start_run(input logic [T_LEN-1:0] t,
                             input logic [DAT_W-1:0] d);
        bus.i_start = 1'b1;
        bus.i_t     = t;
        bus.i_sq_in = d;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_res(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.o_res_val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept_res();
        bus.i_res_rdy = 1'b1;
        @(negedge clk);
        bus.i_res_rdy = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_mul_val !== 1'b0 ||
            bus.o_res_val !== 1'b0 || bus.o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b mv=%b rv=%b err=%b need 0000",
                     bus.o_busy, bus.o_mul_val, bus.o_res_val, bus.o_err);
        end
        n_tests++;
        if (bus.o_iter_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d need 0", bus.o_iter_cnt);
        end
        n_tests++;
        if (bus.o_mul_dat !== '0 || bus.o_res_dat !== '0) begin
            n_fail++;
            $display("FAIL reset_dat: mul=%0h res=%0h need 0",
                     bus.o_mul_dat, bus.o_res_dat);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int x0;
        x0 = xfers;
        start_run(T_LEN'(5), DAT_W'(10));
        wait_res(200, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_timeout: no result, need o_res_val=1");
        end
        n_tests++;
        if (bus.o_res_dat !== DAT_W'(15)) begin
            n_fail++;
            $display("FAIL basic_dat: got %0h need f", bus.o_res_dat);
        end
        n_tests++;
        if (bus.o_iter_cnt !== T_LEN'(5) || (xfers - x0) != 5) begin
            n_fail++;
            $display("FAIL basic_cnt: cnt=%0d xfers=%0d need 5/5",
                     bus.o_iter_cnt, xfers - x0);
        end
        n_tests++;
        if (bus.o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: got %b need 0", bus.o_err);
        end
        accept_res();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_iter_cnt !== T_LEN'(5)) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b cnt=%0d need 0/5",
                     bus.o_busy, bus.o_iter_cnt);
        end
    endtask

    task automatic test_zero();
        int x0;
        x0 = xfers;
        start_run(T_LEN'(0), DAT_W'(7));
        n_tests++;
        if (bus.o_res_val !== 1'b1 || bus.o_res_dat !== DAT_W'(7)) begin
            n_fail++;
            $display("FAIL zero_res: val=%b dat=%0h need 1/7",
                     bus.o_res_val, bus.o_res_dat);
        end
        n_tests++;
        if (bus.o_iter_cnt !== '0 || bus.o_mul_val !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_cnt: cnt=%0d mv=%b need 0/0",
                     bus.o_iter_cnt, bus.o_mul_val);
        end
        accept_res();
        n_tests++;
        if ((xfers - x0) != 0) begin
            n_fail++;
            $display("FAIL zero_xfer: got %0d need 0", xfers - x0);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit stable;
        logic [DAT_W-1:0] snap;
        stable = 1'b1;
        bus.i_mul_rdy = 1'b0;
        start_run(T_LEN'(3), DAT_W'(20));
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 20 && !bus.o_mul_val; w++) @(negedge clk);
            snap = bus.o_mul_dat;
            if (snap !== DAT_W'(20 + k)) stable = 1'b0;
            for (int s = 0; s < 6; s++) begin
                if (bus.o_mul_val !== 1'b1 || bus.o_mul_dat !== snap)
                    stable = 1'b0;
                @(negedge clk);
            end
            bus.i_mul_rdy = 1'b1;
            @(negedge clk);
            bus.i_mul_rdy = 1'b0;
        end
        bus.i_mul_rdy = 1'b1;
        n_tests++;
        if (!stable) begin
            n_fail++;
            $display("FAIL stall_hold: operand moved or dropped, need stable 20/21/22");
        end
        wait_res(50, ok);
        n_tests++;
        if (!ok || bus.o_res_dat !== DAT_W'(23) ||
            bus.o_iter_cnt !== T_LEN'(3)) begin
            n_fail++;
            $display("FAIL stall_res: ok=%b dat=%0h cnt=%0d need 1/17/3",
                     ok, bus.o_res_dat, bus.o_iter_cnt);
        end
        accept_res();
    endtask

    task automatic test_hold();
        bit ok;
        bit held;
        held = 1'b1;
        start_run(T_LEN'(2), DAT_W'(40));
        wait_res(100, ok);
        for (int c = 0; c < 10; c++) begin
            if (bus.o_res_val !== 1'b1 || bus.o_res_dat !== DAT_W'(42) ||
                bus.o_iter_cnt !== T_LEN'(2)) held = 1'b0;
            bus.i_start = (c == 3);
            bus.i_t     = T_LEN'(9);
            bus.i_sq_in = DAT_W'(99);
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        n_tests++;
        if (!ok || !held) begin
            n_fail++;
            $display("FAIL hold_res: ok=%b held=%b dat=%0h need 1/1/2a",
                     ok, held, bus.o_res_dat);
        end
        accept_res();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_res_val !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: busy=%b rv=%b need 0/0",
                     bus.o_busy, bus.o_res_val);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_run(T_LEN'(2), DAT_W'(100));
        wait_res(100, ok);
        n_tests++;
        if (!ok || bus.o_res_dat !== DAT_W'(102)) begin
            n_fail++;
            $display("FAIL b2b_res: ok=%b dat=%0h need 1/66",
                     ok, bus.o_res_dat);
        end
        accept_res();
    endtask

    task automatic test_abort();
        bit ok;
        start_run(T_LEN'(100), DAT_W'(0));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.o_iter_cnt == T_LEN'(3)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (!ok || bus.o_busy !== 1'b0 || bus.o_mul_val !== 1'b0 ||
            bus.o_res_val !== 1'b0 || bus.o_err !== 1'b0 ||
            bus.o_iter_cnt !== '0 || bus.o_mul_dat !== '0 ||
            bus.o_res_dat !== '0) begin
            n_fail++;
            $display("FAIL abort_zero: ok=%b busy=%b mv=%b cnt=%0d need all 0",
                     ok, bus.o_busy, bus.o_mul_val, bus.o_iter_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(T_LEN'(1), DAT_W'(4));
        wait_res(50, ok);
        n_tests++;
        if (!ok || bus.o_res_dat !== DAT_W'(5) || bus.o_err !== 1'b0 ||
            bus.o_iter_cnt !== T_LEN'(1)) begin
            n_fail++;
            $display("FAIL abort_rerun: ok=%b dat=%0h err=%b need 1/5/0",
                     ok, bus.o_res_dat, bus.o_err);
        end
        accept_res();
    endtask

    task automatic test_err();
        bit kept;
        kept = 1'b1;
        inj_val = 1'b1;
        @(negedge clk);
        inj_val = 1'b0;
        n_tests++;
        if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set: err=%b busy=%b need 1/0",
                     bus.o_err, bus.o_busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.o_err !== 1'b1) kept = 1'b0;
        end
        n_tests++;
        if (!kept) begin
            n_fail++;
            $display("FAIL err_sticky: err dropped, need 1");
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (bus.o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b need 0", bus.o_err);
        end
    endtask

    initial begin
        bus.i_start   = 1'b0;
        bus.i_t       = '0;
        bus.i_sq_in   = '0;
        bus.i_mul_rdy = 1'b1;
        bus.i_res_rdy = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_zero();
        test_stall();
        test_hold();
        test_back_to_back();
        test_abort();
        test_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vdf_sq_ctrl.md
VDF_SQ_CTRL -- requirements
Module: vdf_sq_ctrl

Interface
REQ-001 SHALL have parameter T_LEN, default 64, meaning width of iteration count.
REQ-002 SHALL have parameter DAT_W, default 1089, meaning redundant field-element width (33 words x 33 bits).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  start pulse; sampled only in IDLE.
REQ-006 SHALL have port i_t  input  T_LEN  number of squarings requested, captured on accepted start.
REQ-007 SHALL have port i_sq_in  input  DAT_W  initial value in Montgomery redundant form, captured on accepted start.
REQ-008 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port o_mul_val  output  1  operand valid to squaring datapath.
REQ-010 SHALL have port o_mul_dat  output  DAT_W  operand to datapath.
REQ-011 SHALL have port i_mul_rdy  input  1  datapath can accept operand.
REQ-012 SHALL have port i_mul_val  input  1  datapath result valid (single-cycle pulse).
REQ-013 SHALL have port i_mul_dat  input  DAT_W  datapath result.
REQ-014 SHALL have port o_res_val  output  1  final result valid.
REQ-015 SHALL have port o_res_dat  output  DAT_W  final result.
REQ-016 SHALL have port i_res_rdy  input  1  consumer accepts final result.
REQ-017 SHALL have port o_iter_cnt  output  T_LEN  squarings completed in current/last run.
REQ-018 SHALL have port o_err  output  1  sticky protocol error.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: i_start=1 SHALL capture i_t, i_sq_in into operand register, clear o_iter_cnt, go ISSUE if i_t!=0 else DONE.
REQ-021 i_t=0 SHALL yield o_res_dat=i_sq_in, o_res_val=1 the cycle after start, with no datapath transaction.
REQ-022 ISSUE: o_mul_val=1, o_mul_dat=operand register; transfer on o_mul_val&i_mul_rdy, then go WAIT; o_mul_dat SHALL hold stable while stalled.
REQ-023 WAIT: o_mul_val=0; on i_mul_val SHALL load i_mul_dat into operand register and increment o_iter_cnt by 1.
REQ-024 WAIT with i_mul_val: if incremented count equals captured T, go DONE; else go ISSUE (next cycle re-issues the result, one squaring in flight maximum).
REQ-025 DONE: o_res_val=1, o_res_dat=operand register; on i_res_rdy go IDLE the next cycle; o_res_dat and o_iter_cnt SHALL hold until then and o_iter_cnt SHALL retain value in IDLE.
REQ-026 i_start outside IDLE SHALL be ignored; running captured T and data unaffected.
REQ-027 i_mul_val in IDLE, ISSUE or DONE SHALL set o_err and be otherwise ignored; o_err clears only on reset.
REQ-028 o_iter_cnt SHALL count modulo 2^T_LEN; T=2^T_LEN-1 SHALL terminate exactly at that count with no wrap.
REQ-029 Datapath latency SHALL be arbitrary (>=1 cycle); controller SHALL not assume a fixed latency.

Reset
REQ-030 Reset assertion SHALL immediately force IDLE and o_busy=0, o_mul_val=0, o_res_val=0, o_err=0, o_iter_cnt=0, o_mul_dat=0, o_res_dat=0, including mid-run.
REQ-031 After reset deassertion, a datapath result from an aborted run SHALL set o_err (bench drains datapath to avoid).

Verification (datapath model: result = operand+1, latency 4, i_mul_rdy=1 unless stated)
REQ-032 i_t=5, i_sq_in=10 -> exactly 5 transfers, o_res_dat=15, o_iter_cnt=5, o_err=0.
REQ-033 i_t=0, i_sq_in=0x7 -> o_res_val next cycle, o_res_dat=0x7, o_mul_val never high, o_iter_cnt=0.
REQ-034 i_t=3, i_mul_rdy low 6 cycles on each issue -> o_mul_dat stable while stalled, o_res_dat=i_sq_in+3.
REQ-035 i_t=2, i_res_rdy held low 10 cycles in DONE, i_start pulsed meanwhile -> o_res_val/o_res_dat held, start ignored, IDLE one cycle after i_res_rdy.
REQ-036 i_t=100, i_rst_n low after 3rd result -> all outputs zero immediately; new run i_t=1, i_sq_in=4 -> o_res_dat=5.
REQ-037 i_mul_val pulsed in IDLE -> o_err=1 and stays until reset.
